// File: rtl/nvm_pkg.sv
// Shared types for the NVM access sequencer: request opcodes, FSM states
// and a small helper used to size the strobe duration counter.
package nvm_pkg;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_ER  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_VERIFY = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Largest of three strobe durations; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/nvm_timer.sv
// Strobe duration counter: loads a start value, counts down to zero and
// parks there. The zero flag tells the sequencer the current phase is over.
module nvm_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/nvm_ctrl.sv
// NVM access sequencer between the core and the eeprom macro. Accepts one
// request at a time, drives mutually exclusive erase/write/read strobes with
// fixed durations, optionally erases before writing, verifies writes by
// reading them back and reports completion with a one-cycle response pulse.
module nvm_ctrl
  import nvm_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 8,
  parameter int T_RD       = 1,
  parameter int T_WR       = 4,
  parameter int T_ERASE    = 8,
  parameter bit AUTO_ERASE = 1'b1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] ee_addr,
  output logic [DW-1:0] ee_wdata,
  input  logic [DW-1:0] ee_rdata,
  output logic          ee_wr,
  output logic          ee_rd,
  output logic          ee_erase
);

  localparam int TMAX = max3(T_RD, T_WR, T_ERASE);
  localparam int CW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  state_e        state_reg, state_next;
  op_e           op_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          err_reg;
  logic          ready_reg;
  logic          rsp_valid_reg;
  logic          wr_reg, rd_reg, erase_reg;

  logic          accept;
  logic          timer_zero;
  logic          timer_load;
  logic [CW-1:0] timer_load_val;
  logic [DW-1:0] diff;
  logic          mismatch;

  assign accept = req_valid && (state_reg == S_IDLE);

  // Bitwise readback comparison against the data that was written.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_cmp
      assign diff[gi] = ee_rdata[gi] ^ wdata_reg[gi];
    end
  endgenerate
  assign mismatch = |diff;

  // Phase timer: reloaded whenever the FSM moves to a different state.
  nvm_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .nreset   (nreset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and duration selection for the state being entered.
  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_load_val = '0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(req_op))
            OP_RD:   state_next = S_READ;
            OP_WR:   state_next = AUTO_ERASE ? S_ERASE : S_WRITE;
            OP_ER:   state_next = S_ERASE;
            default: state_next = S_DONE;
          endcase
        end
      end
      S_ERASE: begin
        if (timer_zero) state_next = (op_reg == OP_WR) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        if (timer_zero) state_next = S_VERIFY;
      end
      S_READ: begin
        if (timer_zero) state_next = S_DONE;
      end
      S_VERIFY: begin
        if (timer_zero) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (state_next != state_reg) begin
      timer_load = 1'b1;
      case (state_next)
        S_ERASE:  timer_load_val = CW'(T_ERASE - 1);
        S_WRITE:  timer_load_val = CW'(T_WR - 1);
        S_READ:   timer_load_val = CW'(T_RD - 1);
        S_VERIFY: timer_load_val = CW'(T_RD - 1);
        default:  timer_load_val = '0;
      endcase
    end
  end

  // Registered strobes and handshake outputs, decoded from the next state
  // so they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      erase_reg     <= 1'b0;
      wr_reg        <= 1'b0;
      rd_reg        <= 1'b0;
    end else begin
      ready_reg     <= (state_next == S_IDLE);
      rsp_valid_reg <= (state_next == S_DONE);
      erase_reg     <= (state_next == S_ERASE);
      wr_reg        <= (state_next == S_WRITE);
      rd_reg        <= (state_next == S_READ) || (state_next == S_VERIFY);
    end
  end

  // Request capture, read data capture and error flag.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      op_reg    <= OP_RD;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= op_e'(req_op);
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        // A reserved op completes immediately with the error flag raised;
        // any other op starts with the flag cleared.
        err_reg   <= (op_e'(req_op) == OP_RSV);
      end
      // Sample the macro on the edge that closes the last read cycle.
      if (((state_reg == S_READ) || (state_reg == S_VERIFY)) && timer_zero) begin
        rdata_reg <= ee_rdata;
      end
      if ((state_reg == S_VERIFY) && timer_zero) begin
        err_reg <= mismatch;
      end
    end
  end

  assign req_ready = ready_reg;
  assign busy      = !ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign ee_addr   = addr_reg;
  assign ee_wdata  = wdata_reg;
  assign ee_wr     = wr_reg;
  assign ee_rd     = rd_reg;
  assign ee_erase  = erase_reg;

endmodule

// File: tb/tb_nvm_ctrl.sv
// Self-checking bench for nvm_ctrl: default instance plus a second instance
// without auto-erase and a shorter write pulse, each with its own NVM model.
module tb_nvm_ctrl;

  localparam int T_RD    = 1;
  localparam int T_WR    = 4;
  localparam int T_ERASE = 8;
  localparam int T_WR2   = 2;

  logic       clk = 1'b0;
  logic       nreset;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_wdata;

  logic       req_valid, req_ready, rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata, ee_addr, ee_wdata, ee_rdata;
  logic       ee_wr, ee_rd, ee_erase;

  logic       req_valid2, req_ready2, rsp_valid2, rsp_err2, busy2;
  logic [7:0] rsp_rdata2, ee_addr2, ee_wdata2, ee_rdata2;
  logic       ee_wr2, ee_rd2, ee_erase2;

  always #5 clk = ~clk;

  nvm_ctrl dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .ee_addr(ee_addr), .ee_wdata(ee_wdata), .ee_rdata(ee_rdata),
    .ee_wr(ee_wr), .ee_rd(ee_rd), .ee_erase(ee_erase)
  );

  nvm_ctrl #(.AUTO_ERASE(1'b0), .T_WR(T_WR2)) dut2 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
    .ee_addr(ee_addr2), .ee_wdata(ee_wdata2), .ee_rdata(ee_rdata2),
    .ee_wr(ee_wr2), .ee_rd(ee_rd2), .ee_erase(ee_erase2)
  );

  // NVM models: erase sets a cell to FF, write stores data, optional stuck read.
  logic [7:0] mem  [0:255];
  logic [7:0] mem2 [0:255];
  logic       stuck_en;
  logic       bk_we;
  logic [7:0] bk_addr, bk_data;

  assign ee_rdata  = stuck_en ? 8'hF0 : mem[ee_addr];
  assign ee_rdata2 = mem2[ee_addr2];

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (ee_wr) mem[ee_addr] <= ee_wdata;
    else if (ee_erase) mem[ee_addr] <= 8'hFF;
  end

  always @(posedge clk) begin
    if (ee_wr2) mem2[ee_addr2] <= ee_wdata2;
    else if (ee_erase2) mem2[ee_addr2] <= 8'hFF;
  end

  // Cycle counter and passive monitors (strobe totals, exclusivity, pulses).
  int cyc = 0;
  int rd_tot = 0, wr_tot = 0, er_tot = 0;
  int rd_tot2 = 0, wr_tot2 = 0, er_tot2 = 0;
  int excl_viol = 0;
  int rsp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rd_tot  = rd_tot  + int'(ee_rd);
    wr_tot  = wr_tot  + int'(ee_wr);
    er_tot  = er_tot  + int'(ee_erase);
    rd_tot2 = rd_tot2 + int'(ee_rd2);
    wr_tot2 = wr_tot2 + int'(ee_wr2);
    er_tot2 = er_tot2 + int'(ee_erase2);
    if ((int'(ee_rd) + int'(ee_wr) + int'(ee_erase)) > 1) excl_viol = excl_viol + 1;
    if ((int'(ee_rd2) + int'(ee_wr2) + int'(ee_erase2)) > 1) excl_viol = excl_viol + 1;
    rsp_seen = rsp_seen + int'(rsp_valid) + int'(rsp_valid2);
  end

  // Scoreboard of expected responses.
  typedef struct {
    logic [7:0] rdata;
    bit         chk_rdata;
    bit         err;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   issued = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bk_addr = a; bk_data = d; bk_we = 1'b1;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  // Drive one request on the chosen instance and record its expectation.
  task automatic drive_req(input bit sel, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] wd, input int lat, input logic [7:0] erd,
                           input bit chk, input bit eerr, input string name);
    exp_t e;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd;
    if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
    total_cnt++;
    if ((sel ? req_ready2 : req_ready) !== 1'b1)
      $display("FAIL %s ready_at_issue: got %b want 1", name, sel ? req_ready2 : req_ready);
    else pass_cnt++;
    e.rdata = erd; e.chk_rdata = chk; e.err = eerr; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    issued++;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_valid2 = 1'b0;
  endtask

  // Wait (bounded) for the response pulse, then pop and compare.
  task automatic wait_rsp(input bit sel);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? rsp_valid2 : rsp_valid) === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen || sb.size() == 0) begin
      $display("FAIL rsp_timeout: got no response want one (pending %0d)", sb.size());
      return;
    end
    pass_cnt++;
    e = sb.pop_front();
    $display("rsp %s: cyc=%0d rdata=%h err=%b", e.name, cyc,
             sel ? rsp_rdata2 : rsp_rdata, sel ? rsp_err2 : rsp_err);
    total_cnt++;
    if (cyc !== e.cyc) $display("FAIL %s rsp_cycle: got %0d want %0d", e.name, cyc, e.cyc);
    else pass_cnt++;
    total_cnt++;
    if ((sel ? rsp_err2 : rsp_err) !== e.err)
      $display("FAIL %s rsp_err: got %b want %b", e.name, sel ? rsp_err2 : rsp_err, e.err);
    else pass_cnt++;
    if (e.chk_rdata) begin
      total_cnt++;
      if ((sel ? rsp_rdata2 : rsp_rdata) !== e.rdata)
        $display("FAIL %s rsp_rdata: got %h want %h", e.name, sel ? rsp_rdata2 : rsp_rdata, e.rdata);
      else pass_cnt++;
    end
  endtask

  // Full transaction: issue, await response, check strobe lengths and ready.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] wd, input int lat, input logic [7:0] erd,
                        input bit chk, input bit eerr, input int ner, input int nwr,
                        input int nrd, input string name);
    int r0, w0, e0;
    r0 = sel ? rd_tot2 : rd_tot;
    w0 = sel ? wr_tot2 : wr_tot;
    e0 = sel ? er_tot2 : er_tot;
    drive_req(sel, op, a, wd, lat, erd, chk, eerr, name);
    wait_rsp(sel);
    total_cnt++;
    if ((sel ? er_tot2 : er_tot) - e0 !== ner)
      $display("FAIL %s erase_cycles: got %0d want %0d", name, (sel ? er_tot2 : er_tot) - e0, ner);
    else pass_cnt++;
    total_cnt++;
    if ((sel ? wr_tot2 : wr_tot) - w0 !== nwr)
      $display("FAIL %s write_cycles: got %0d want %0d", name, (sel ? wr_tot2 : wr_tot) - w0, nwr);
    else pass_cnt++;
    total_cnt++;
    if ((sel ? rd_tot2 : rd_tot) - r0 !== nrd)
      $display("FAIL %s read_cycles: got %0d want %0d", name, (sel ? rd_tot2 : rd_tot) - r0, nrd);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ((sel ? req_ready2 : req_ready) !== 1'b1)
      $display("FAIL %s ready_after: got %b want 1", name, sel ? req_ready2 : req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({ee_wr, ee_rd, ee_erase, rsp_valid, rsp_err} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {ee_wr, ee_rd, ee_erase, rsp_valid, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if ({rsp_rdata, ee_addr, ee_wdata} !== 24'h0)
      $display("FAIL reset_regs: got %h want 000000", {rsp_rdata, ee_addr, ee_wdata});
    else pass_cnt++;
    nreset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, busy, req_ready2, busy2} !== 4'b1010)
      $display("FAIL reset_ready: got %b want 1010", {req_ready, busy, req_ready2, busy2});
    else pass_cnt++;
  endtask

  task automatic test_read;
    preload(8'h3C, 8'hA5);
    run_op(1'b0, 2'b00, 8'h3C, 8'h00, T_RD + 1, 8'hA5, 1'b1, 1'b0, 0, 0, T_RD, "read_3c");
  endtask

  task automatic test_write;
    preload(8'h10, 8'h00);
    run_op(1'b0, 2'b01, 8'h10, 8'h5A, T_ERASE + T_WR + T_RD + 1, 8'h5A, 1'b1, 1'b0,
           T_ERASE, T_WR, T_RD, "write_10");
    total_cnt++;
    if (mem[8'h10] !== 8'h5A) $display("FAIL write_cell: got %h want 5a", mem[8'h10]);
    else pass_cnt++;
  endtask

  task automatic test_verify_fail;
    stuck_en = 1'b1;
    run_op(1'b0, 2'b01, 8'h20, 8'hFF, T_ERASE + T_WR + T_RD + 1, 8'hF0, 1'b1, 1'b1,
           T_ERASE, T_WR, T_RD, "write_stuck");
    stuck_en = 1'b0;
  endtask

  task automatic test_reserved_and_busy;
    int e0;
    run_op(1'b0, 2'b11, 8'h55, 8'h00, 1, 8'h00, 1'b0, 1'b1, 0, 0, 0, "reserved");
    preload(8'h44, 8'h12);
    e0 = er_tot;
    drive_req(1'b0, 2'b10, 8'h44, 8'h00, T_ERASE + 1, 8'h00, 1'b0, 1'b0, "erase_44");
    req_op = 2'b00; req_addr = 8'h3C; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", req_ready);
    else pass_cnt++;
    req_valid = 1'b0;
    wait_rsp(1'b0);
    total_cnt++;
    if (er_tot - e0 !== T_ERASE) $display("FAIL erase_cycles: got %0d want %0d", er_tot - e0, T_ERASE);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (mem[8'h44] !== 8'hFF) $display("FAIL erase_cell: got %h want ff", mem[8'h44]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write;
    int n;
    @(negedge clk);
    req_op = 2'b01; req_addr = 8'h66; req_wdata = 8'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (ee_wr) n++;
    end
    total_cnt++;
    if (n !== 3) $display("FAIL midreset_wr_seen: got %0d want 3", n);
    else pass_cnt++;
    nreset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ee_wr, ee_rd, ee_erase, rsp_valid, rsp_err} !== 5'b0)
      $display("FAIL midreset_outputs: got %b want 00000", {ee_wr, ee_rd, ee_erase, rsp_valid, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if ({rsp_rdata, ee_addr, ee_wdata} !== 24'h0)
      $display("FAIL midreset_regs: got %h want 000000", {rsp_rdata, ee_addr, ee_wdata});
    else pass_cnt++;
    nreset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", req_ready);
    else pass_cnt++;
    run_op(1'b0, 2'b00, 8'h3C, 8'h00, T_RD + 1, 8'hA5, 1'b1, 1'b0, 0, 0, T_RD, "read_after_reset");
  endtask

  task automatic test_no_auto_erase;
    run_op(1'b1, 2'b01, 8'h21, 8'h33, T_WR2 + T_RD + 1, 8'h33, 1'b1, 1'b0,
           0, T_WR2, T_RD, "write2_21");
    total_cnt++;
    if (mem2[8'h21] !== 8'h33) $display("FAIL write2_cell: got %h want 33", mem2[8'h21]);
    else pass_cnt++;
  endtask

  task automatic test_final;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (excl_viol !== 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_viol);
    else pass_cnt++;
    total_cnt++;
    if (rsp_seen !== issued) $display("FAIL rsp_count: got %0d pulses want %0d", rsp_seen, issued);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() !== 0) $display("FAIL sb_empty: got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
    req_op = 2'b00; req_addr = 8'h00; req_wdata = 8'h00;
    stuck_en = 1'b0; bk_we = 1'b0; bk_addr = 8'h00; bk_data = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_verify_fail();
    test_reserved_and_busy();
    test_reset_mid_write();
    test_no_auto_erase();
    test_final();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
